// File: rtl/load_use_hazard_unit_pkg.sv
// pipeline_pkg
// Shared definitions for the integer pipeline control blocks:
//   - RV32 base opcode constants used by hazard detection
//   - instruction register-field bit positions
//   - reg_idx_t register index type and scoreboard entry struct
//   - small field-extraction and operand-usage helpers
package pipeline_pkg;

    typedef logic [4:0] reg_idx_t;
    typedef logic [6:0] opcode_t;

    localparam opcode_t OP_LOAD   = 7'b0000011;
    localparam opcode_t OP_OP     = 7'b0110011;
    localparam opcode_t OP_STORE  = 7'b0100011;
    localparam opcode_t OP_BRANCH = 7'b1100011;
    localparam opcode_t OP_LUI    = 7'b0110111;
    localparam opcode_t OP_AUIPC  = 7'b0010111;
    localparam opcode_t OP_JAL    = 7'b1101111;

    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 6;
    localparam int RD_LSB  = 7;
    localparam int RD_MSB  = 11;
    localparam int RS1_LSB = 15;
    localparam int RS1_MSB = 19;
    localparam int RS2_LSB = 20;
    localparam int RS2_MSB = 24;

    // One in-flight load that has already left EX.
    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
    } sb_entry_t;

    function automatic opcode_t get_opcode(input logic [31:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

    function automatic reg_idx_t get_rd(input logic [11:0] instr_lo);
        return instr_lo[RD_MSB:RD_LSB];
    endfunction

    function automatic reg_idx_t get_rs1(input logic [31:0] instr);
        return instr[RS1_MSB:RS1_LSB];
    endfunction

    function automatic reg_idx_t get_rs2(input logic [31:0] instr);
        return instr[RS2_MSB:RS2_LSB];
    endfunction

    // Upper-immediate and JAL formats carry immediate bits where rs1 sits.
    function automatic logic reads_rs1(input opcode_t op);
        return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
    endfunction

    function automatic logic reads_rs2(input opcode_t op);
        return (op == OP_OP) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/load_use_hazard_unit_if.sv
// load_use_hazard_unit_if
// Decode/Execute view of the pipeline seen by the load-use hazard unit.
//   instruction_D / valid_D   : instruction in Decode and its live flag
//   instruction_EX / valid_EX : instruction in Execute (valid_EX=0 for a bubble)
//   flush_D                   : Decode instruction is being killed this cycle
//   stall_FD                  : hold PC and the IF/ID register
//   bubble_EX                 : load a NOP into ID/EX (same value as stall_FD)
// master = pipeline side, slave = hazard unit side.
interface load_use_hazard_unit_if;
    logic [31:0] instruction_D;
    logic        valid_D;
    logic [31:0] instruction_EX;
    logic        valid_EX;
    logic        flush_D;
    logic        stall_FD;
    logic        bubble_EX;

    modport master (
        output instruction_D,
        output valid_D,
        output instruction_EX,
        output valid_EX,
        output flush_D,
        input  stall_FD,
        input  bubble_EX
    );

    modport slave (
        input  instruction_D,
        input  valid_D,
        input  instruction_EX,
        input  valid_EX,
        input  flush_D,
        output stall_FD,
        output bubble_EX
    );
endinterface

// File: rtl/load_use_hazard_unit_scoreboard.sv
// load_scoreboard
// Age-ordered shift chain of loads that have left EX but whose data is not
// yet forwardable. Entry k holds the load that was in EX k+1 cycles ago.
// Ports:
//   clk, rst_n          : clock, async active-low reset (clears all entries)
//   advance             : shift enable; low during a global pipeline freeze
//   load_valid, load_rd : EX-stage load (valid and destination) entering entry 0
//   rs1, rs2            : Decode source registers to compare
//   hit_rs1, hit_rs2    : some valid entry's rd matches the respective source
// DEPTH=0 yields no storage and constant-zero hits.
module load_scoreboard
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 0
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     advance,
    input  logic     load_valid,
    input  reg_idx_t load_rd,
    input  reg_idx_t rs1,
    input  reg_idx_t rs2,
    output logic     hit_rs1,
    output logic     hit_rs2
);

    generate
        if (DEPTH > 0) begin : g_chain
            sb_entry_t entries [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        entries[k] <= '0;
                    end
                end else if (advance) begin
                    entries[0] <= '{valid: load_valid, rd: load_rd};
                    for (int k = 1; k < DEPTH; k++) begin
                        entries[k] <= entries[k-1];
                    end
                end
            end

            always_comb begin
                hit_rs1 = 1'b0;
                hit_rs2 = 1'b0;
                for (int k = 0; k < DEPTH; k++) begin
                    if (entries[k].valid && (entries[k].rd == rs1)) begin
                        hit_rs1 = 1'b1;
                    end
                    if (entries[k].valid && (entries[k].rd == rs2)) begin
                        hit_rs2 = 1'b1;
                    end
                end
            end
        end else begin : g_empty
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst_n, advance, load_valid, load_rd, rs1, rs2};
            assign hit_rs1 = 1'b0;
            assign hit_rs2 = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/load_use_hazard_unit.sv
// load_use_hazard_unit
// Load-use hazard detector between Decode and Execute. A Decode source that
// matches the rd of a load in EX, or of a younger-than-LOAD_LAT load tracked
// in the scoreboard, holds Fetch/Decode and injects a bubble into EX.
// Parameters:
//   LOAD_LAT  : cycles from load in EX to earliest consumer in EX (2..8)
//   CHECK_RS2 : also check rs2 for OP/STORE/BRANCH
//   CNT_W     : width of the saturating stall counter
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   bus          : Decode/Execute instruction view, stall/bubble outputs
//   unit_enable  : 0 forces stall/bubble low (scoreboard still tracks)
//   pipe_hold    : global freeze; scoreboard and counter hold
//   cnt_clear    : synchronous clear of stall_count (beats increment)
//   stall_count  : number of non-frozen stall cycles, saturating
module load_use_hazard_unit
    import pipeline_pkg::*;
#(
    parameter int LOAD_LAT  = 2,
    parameter bit CHECK_RS2 = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    load_use_hazard_unit_if.slave bus,
    input  logic                 unit_enable,
    input  logic                 pipe_hold,
    input  logic                 cnt_clear,
    output logic [CNT_W-1:0]     stall_count
);

    localparam int SB_DEPTH = LOAD_LAT - 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    opcode_t  op_d;
    opcode_t  op_ex;
    reg_idx_t rs1_d;
    reg_idx_t rs2_d;
    reg_idx_t rd_ex;
    logic     ex_is_load;
    logic     use_rs1;
    logic     use_rs2;
    logic     sb_hit_rs1;
    logic     sb_hit_rs2;
    logic     hazard;
    logic     stall;

    // Fields of the instruction words that play no part in hazard detection.
    logic unused_fields;
    assign unused_fields = ^{bus.instruction_D[31:25], bus.instruction_D[14:7],
                             bus.instruction_EX[31:12]};

    assign op_d  = get_opcode(bus.instruction_D);
    assign rs1_d = get_rs1(bus.instruction_D);
    assign rs2_d = get_rs2(bus.instruction_D);
    assign op_ex = get_opcode(bus.instruction_EX);
    assign rd_ex = get_rd(bus.instruction_EX[11:0]);

    // A load to x0 produces nothing to wait for.
    assign ex_is_load = bus.valid_EX && (op_ex == OP_LOAD) && (rd_ex != '0);

    // x0 sources are never hazards; the zero check also keeps stale rd==0
    // scoreboard entries (which cannot be valid anyway) out of the picture.
    assign use_rs1 = reads_rs1(op_d) && (rs1_d != '0);
    assign use_rs2 = CHECK_RS2 && reads_rs2(op_d) && (rs2_d != '0);

    load_scoreboard #(
        .DEPTH (SB_DEPTH)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .advance    (!pipe_hold),
        .load_valid (ex_is_load),
        .load_rd    (rd_ex),
        .rs1        (rs1_d),
        .rs2        (rs2_d),
        .hit_rs1    (sb_hit_rs1),
        .hit_rs2    (sb_hit_rs2)
    );

    assign hazard = (use_rs1 && ((ex_is_load && (rd_ex == rs1_d)) || sb_hit_rs1))
                 || (use_rs2 && ((ex_is_load && (rd_ex == rs2_d)) || sb_hit_rs2));

    assign stall = unit_enable && bus.valid_D && !bus.flush_D && hazard;

    assign bus.stall_FD  = stall;
    assign bus.bubble_EX = stall;

    // Software clear is honoured even while the pipe is frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (cnt_clear) begin
            stall_count <= '0;
        end else if (stall && !pipe_hold && (stall_count != CNT_MAX)) begin
            stall_count <= stall_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_load_use_hazard_unit.sv
module tb_load_use_hazard_unit;
    import pipeline_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr_d = '0;
    logic [31:0] instr_ex = '0;
    logic        valid_d = 1'b0;
    logic        valid_ex = 1'b0;
    logic        flush_d = 1'b0;
    logic        unit_enable = 1'b1;
    logic        pipe_hold = 1'b0;
    logic        cnt_clear = 1'b0;

    logic [15:0] cnt2;
    logic [15:0] cnt3;
    logic [3:0]  cnt4;
    logic [15:0] cnt2n;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    load_use_hazard_unit_if if2 ();
    load_use_hazard_unit_if if3 ();
    load_use_hazard_unit_if if4 ();
    load_use_hazard_unit_if if2n ();

    assign if2.instruction_D  = instr_d;
    assign if2.valid_D        = valid_d;
    assign if2.instruction_EX = instr_ex;
    assign if2.valid_EX       = valid_ex;
    assign if2.flush_D        = flush_d;
    assign if3.instruction_D  = instr_d;
    assign if3.valid_D        = valid_d;
    assign if3.instruction_EX = instr_ex;
    assign if3.valid_EX       = valid_ex;
    assign if3.flush_D        = flush_d;
    assign if4.instruction_D  = instr_d;
    assign if4.valid_D        = valid_d;
    assign if4.instruction_EX = instr_ex;
    assign if4.valid_EX       = valid_ex;
    assign if4.flush_D        = flush_d;
    assign if2n.instruction_D  = instr_d;
    assign if2n.valid_D        = valid_d;
    assign if2n.instruction_EX = instr_ex;
    assign if2n.valid_EX       = valid_ex;
    assign if2n.flush_D        = flush_d;

    load_use_hazard_unit #(.LOAD_LAT(2), .CHECK_RS2(1'b1), .CNT_W(16)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(if2), .unit_enable(unit_enable),
        .pipe_hold(pipe_hold), .cnt_clear(cnt_clear), .stall_count(cnt2));
    load_use_hazard_unit #(.LOAD_LAT(3), .CHECK_RS2(1'b1), .CNT_W(16)) u3 (
        .clk(clk), .rst_n(rst_n), .bus(if3), .unit_enable(unit_enable),
        .pipe_hold(pipe_hold), .cnt_clear(cnt_clear), .stall_count(cnt3));
    load_use_hazard_unit #(.LOAD_LAT(4), .CHECK_RS2(1'b1), .CNT_W(4)) u4 (
        .clk(clk), .rst_n(rst_n), .bus(if4), .unit_enable(unit_enable),
        .pipe_hold(pipe_hold), .cnt_clear(cnt_clear), .stall_count(cnt4));
    load_use_hazard_unit #(.LOAD_LAT(2), .CHECK_RS2(1'b0), .CNT_W(16)) u2n (
        .clk(clk), .rst_n(rst_n), .bus(if2n), .unit_enable(unit_enable),
        .pipe_hold(pipe_hold), .cnt_clear(cnt_clear), .stall_count(cnt2n));

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b010, rd, op};
    endfunction

    function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] base);
        return enc(OP_LOAD, rd, base, 5'd0);
    endfunction

    function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
        return enc(OP_OP, rd, a, b);
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] a);
        return enc(7'b0010011, rd, a, 5'd0);
    endfunction

    function automatic logic [31:0] sw(input logic [4:0] data, input logic [4:0] base);
        return enc(OP_STORE, 5'd0, base, data);
    endfunction

    task automatic drive(input logic [31:0] ex, input logic vex, input logic [31:0] d, input logic vd);
        instr_ex = ex;
        valid_ex = vex;
        instr_d  = d;
        valid_d  = vd;
    endtask

    // Idles the pipe long enough to drain every scoreboard and zeroes counters.
    task automatic clear_all();
        drive(32'd0, 1'b0, 32'd0, 1'b0);
        flush_d     = 1'b0;
        pipe_hold   = 1'b0;
        unit_enable = 1'b1;
        cnt_clear   = 1'b1;
        repeat (3) @(negedge clk);
        cnt_clear = 1'b0;
    endtask

    task automatic test_reset();
        drive(32'd0, 1'b0, 32'd0, 1'b0);
        #1;
        vectors++;
        if (if2.stall_FD !== 1'b0 || if2.bubble_EX !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: got %b/%b expected 0/0", if2.stall_FD, if2.bubble_EX);
        end
        vectors++;
        if (cnt2 !== 16'd0 || cnt3 !== 16'd0 || cnt4 !== 4'd0 || cnt2n !== 16'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d %0d %0d %0d expected 0", cnt2, cnt3, cnt4, cnt2n);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lat2();
        clear_all();
        drive(lw(5'd5, 5'd1), 1'b1, add(5'd6, 5'd5, 5'd7), 1'b1);
        #1;
        vectors++;
        if (if2.stall_FD !== 1'b1 || if2.bubble_EX !== 1'b1) begin
            errors++;
            $display("FAIL lat2_stall: got %b/%b expected 1/1", if2.stall_FD, if2.bubble_EX);
        end
        vectors++;
        if (if2n.stall_FD !== 1'b1) begin
            errors++;
            $display("FAIL lat2_rs1_norS2: got %b expected 1", if2n.stall_FD);
        end
        @(negedge clk);
        drive(32'd0, 1'b0, add(5'd6, 5'd5, 5'd7), 1'b1);
        #1;
        vectors++;
        if (if2.stall_FD !== 1'b0) begin
            errors++;
            $display("FAIL lat2_release: got %b expected 0", if2.stall_FD);
        end
        @(negedge clk);
        drive(32'd0, 1'b0, 32'd0, 1'b0);
        #1;
        vectors++;
        if (cnt2 !== 16'd1) begin
            errors++;
            $display("FAIL lat2_count: got %0d expected 1", cnt2);
        end
    endtask

    task automatic test_lat4();
        logic exp_stall [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic exp_gap   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        clear_all();
        for (int i = 0; i < 4; i++) begin
            if (i == 0) drive(lw(5'd5, 5'd1), 1'b1, add(5'd6, 5'd5, 5'd7), 1'b1);
            else        drive(32'd0, 1'b0, add(5'd6, 5'd5, 5'd7), 1'b1);
            #1;
            vectors++;
            if (if4.stall_FD !== exp_stall[i]) begin
                errors++;
                $display("FAIL lat4_immediate[%0d]: got %b expected %b", i, if4.stall_FD, exp_stall[i]);
            end
            @(negedge clk);
        end
        drive(32'd0, 1'b0, 32'd0, 1'b0);
        #1;
        vectors++;
        if (cnt4 !== 4'd3) begin
            errors++;
            $display("FAIL lat4_immediate_count: got %0d expected 3", cnt4);
        end
        clear_all();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       drive(lw(5'd5, 5'd1), 1'b1, addi(5'd10, 5'd11), 1'b1);
                1:       drive(addi(5'd10, 5'd11), 1'b1, add(5'd6, 5'd5, 5'd7), 1'b1);
                default: drive(32'd0, 1'b0, add(5'd6, 5'd5, 5'd7), 1'b1);
            endcase
            #1;
            vectors++;
            if (if4.stall_FD !== exp_gap[i]) begin
                errors++;
                $display("FAIL lat4_gap1[%0d]: got %b expected %b", i, if4.stall_FD, exp_gap[i]);
            end
            @(negedge clk);
        end
        drive(32'd0, 1'b0, 32'd0, 1'b0);
        #1;
        vectors++;
        if (cnt4 !== 4'd2) begin
            errors++;
            $display("FAIL lat4_gap1_count: got %0d expected 2", cnt4);
        end
    endtask

    task automatic test_rs2();
        clear_all();
        drive(lw(5'd9, 5'd3), 1'b1, sw(5'd1, 5'd9), 1'b1);
        #1;
        vectors++;
        if (if2.stall_FD !== 1'b1 || if2n.stall_FD !== 1'b1) begin
            errors++;
            $display("FAIL rs2_store_base: got %b/%b expected 1/1", if2.stall_FD, if2n.stall_FD);
        end
        drive(lw(5'd9, 5'd3), 1'b1, sw(5'd9, 5'd2), 1'b1);
        #1;
        vectors++;
        if (if2.stall_FD !== 1'b1 || if2n.stall_FD !== 1'b0) begin
            errors++;
            $display("FAIL rs2_store_data: got %b/%b expected 1/0", if2.stall_FD, if2n.stall_FD);
        end
        drive(lw(5'd9, 5'd3), 1'b1, enc(OP_BRANCH, 5'd0, 5'd3, 5'd9), 1'b1);
        #1;
        vectors++;
        if (if2.stall_FD !== 1'b1 || if2n.stall_FD !== 1'b0) begin
            errors++;
            $display("FAIL rs2_branch: got %b/%b expected 1/0", if2.stall_FD, if2n.stall_FD);
        end
        @(negedge clk);
    endtask

    task automatic test_no_hazard();
        clear_all();
        drive(lw(5'd0, 5'd1), 1'b1, add(5'd6, 5'd0, 5'd0), 1'b1);
        #1;
        vectors++;
        if (if2.stall_FD !== 1'b0 || if3.stall_FD !== 1'b0) begin
            errors++;
            $display("FAIL x0_load: got %b/%b expected 0/0", if2.stall_FD, if3.stall_FD);
        end
        drive(lw(5'd5, 5'd1), 1'b1, enc(OP_LUI, 5'd5, 5'd5, 5'd5), 1'b1);
        #1;
        vectors++;
        if (if2.stall_FD !== 1'b0) begin
            errors++;
            $display("FAIL lui_no_rs1: got %b expected 0", if2.stall_FD);
        end
        drive(lw(5'd5, 5'd1), 1'b0, add(5'd6, 5'd5, 5'd7), 1'b1);
        #1;
        vectors++;
        if (if2.stall_FD !== 1'b0) begin
            errors++;
            $display("FAIL invalid_ex: got %b expected 0", if2.stall_FD);
        end
        drive(lw(5'd5, 5'd1), 1'b1, add(5'd6, 5'd5, 5'd7), 1'b0);
        #1;
        vectors++;
        if (if2.stall_FD !== 1'b0) begin
            errors++;
            $display("FAIL invalid_d: got %b expected 0", if2.stall_FD);
        end
        drive(lw(5'd5, 5'd1), 1'b1, add(5'd6, 5'd5, 5'd7), 1'b1);
        unit_enable = 1'b0;
        #1;
        vectors++;
        if (if2.stall_FD !== 1'b0 || if2.bubble_EX !== 1'b0) begin
            errors++;
            $display("FAIL unit_disabled: got %b/%b expected 0/0", if2.stall_FD, if2.bubble_EX);
        end
        unit_enable = 1'b1;
        clear_all();
        drive(lw(5'd5, 5'd1), 1'b1, add(5'd6, 5'd5, 5'd7), 1'b1);
        flush_d = 1'b1;
        #1;
        vectors++;
        if (if3.stall_FD !== 1'b0 || if2.stall_FD !== 1'b0) begin
            errors++;
            $display("FAIL flush_blocks: got %b/%b expected 0/0", if3.stall_FD, if2.stall_FD);
        end
        @(negedge clk);
        flush_d = 1'b0;
        drive(32'd0, 1'b0, add(5'd6, 5'd5, 5'd7), 1'b1);
        #1;
        vectors++;
        if (if3.stall_FD !== 1'b1 || if2.stall_FD !== 1'b0) begin
            errors++;
            $display("FAIL flush_recorded: got %b/%b expected 1/0", if3.stall_FD, if2.stall_FD);
        end
        @(negedge clk);
    endtask

    task automatic test_hold();
        logic       hold_seq  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       stall_seq [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0] cnt_seq   [5] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
        clear_all();
        for (int i = 0; i < 5; i++) begin
            if (i == 0) drive(lw(5'd5, 5'd1), 1'b1, add(5'd6, 5'd5, 5'd7), 1'b1);
            else        drive(32'd0, 1'b0, add(5'd6, 5'd5, 5'd7), 1'b1);
            pipe_hold = hold_seq[i];
            #1;
            vectors++;
            if (if3.stall_FD !== stall_seq[i]) begin
                errors++;
                $display("FAIL hold_stall[%0d]: got %b expected %b", i, if3.stall_FD, stall_seq[i]);
            end
            @(negedge clk);
            #1;
            vectors++;
            if (cnt3 !== {14'd0, cnt_seq[i]}) begin
                errors++;
                $display("FAIL hold_count[%0d]: got %0d expected %0d", i, cnt3, cnt_seq[i]);
            end
        end
        pipe_hold = 1'b0;
    endtask

    task automatic test_saturate_clear();
        clear_all();
        drive(lw(5'd5, 5'd1), 1'b1, add(5'd6, 5'd5, 5'd7), 1'b1);
        repeat (14) @(negedge clk);
        #1;
        vectors++;
        if (cnt4 !== 4'd14) begin
            errors++;
            $display("FAIL count_14: got %0d expected 14", cnt4);
        end
        repeat (6) @(negedge clk);
        #1;
        vectors++;
        if (cnt4 !== 4'd15 || if4.stall_FD !== 1'b1) begin
            errors++;
            $display("FAIL count_saturate: got %0d stall %b expected 15 stall 1", cnt4, if4.stall_FD);
        end
        cnt_clear = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0;
        #1;
        vectors++;
        if (cnt4 !== 4'd0 || cnt2 !== 16'd0) begin
            errors++;
            $display("FAIL count_clear: got %0d/%0d expected 0/0", cnt4, cnt2);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (cnt4 !== 4'd1) begin
            errors++;
            $display("FAIL count_after_clear: got %0d expected 1", cnt4);
        end
    endtask

    task automatic test_reset_mid_stall();
        clear_all();
        drive(lw(5'd5, 5'd1), 1'b1, add(5'd6, 5'd5, 5'd7), 1'b1);
        @(negedge clk);
        drive(32'd0, 1'b0, add(5'd6, 5'd5, 5'd7), 1'b1);
        #1;
        vectors++;
        if (if3.stall_FD !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: got %b expected 1", if3.stall_FD);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (if3.stall_FD !== 1'b0 || if3.bubble_EX !== 1'b0 || cnt3 !== 16'd0) begin
            errors++;
            $display("FAIL midreset_assert: got %b/%b cnt %0d expected 0/0 cnt 0",
                     if3.stall_FD, if3.bubble_EX, cnt3);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (if3.stall_FD !== 1'b0) begin
            errors++;
            $display("FAIL midreset_release: got %b expected 0", if3.stall_FD);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (cnt3 !== 16'd0 || if3.stall_FD !== 1'b0) begin
            errors++;
            $display("FAIL midreset_after: got cnt %0d stall %b expected 0/0", cnt3, if3.stall_FD);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_lat2();
        test_lat4();
        test_rs2();
        test_no_hazard();
        test_hold();
        test_saturate_clear();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
